// File: rtl/acc_pkg.sv
// Shared widths, saturation limits and requantization helpers for the psum
// writeback path and the later bias/ReLU stage.
package acc_pkg;

    localparam int LANES   = 16;
    localparam int PSUM_W  = 16;
    localparam int ACC_W   = 24;
    localparam int OUT_W   = 8;
    localparam int ADDR_W  = 13;
    localparam int SHIFT_W = 6;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // One entry of the output FIFO: destination address plus packed int8 lanes.
    typedef struct packed {
        logic [ADDR_W-1:0]      addr;
        logic [LANES*OUT_W-1:0] data;
    } wb_word_t;

    function automatic logic signed [ACC_W-1:0] sat_acc_add(
        input logic signed [ACC_W-1:0]  acc,
        input logic signed [PSUM_W-1:0] psum
    );
        logic signed [ACC_W:0] sum;
        sum = (ACC_W+1)'(acc) + (ACC_W+1)'(psum);
        if (sum > (ACC_W+1)'(ACC_MAX)) begin
            return ACC_MAX;
        end
        if (sum < (ACC_W+1)'(ACC_MIN)) begin
            return ACC_MIN;
        end
        return sum[ACC_W-1:0];
    endfunction

    // Round-half-up arithmetic shift with the shift clamped to ACC_W-1, then
    // saturate to the signed output range.
    function automatic logic signed [OUT_W-1:0] requant(
        input logic signed [ACC_W-1:0] sum,
        input logic [SHIFT_W-1:0]      shift
    );
        logic [SHIFT_W-1:0]    s;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] y;
        s   = (shift > SHIFT_W'(ACC_W - 1)) ? SHIFT_W'(ACC_W - 1) : shift;
        rnd = '0;
        if (s != '0) begin
            rnd = (ACC_W+1)'(1) << (s - SHIFT_W'(1));
        end
        y = ((ACC_W+1)'(sum) + rnd) >>> s;
        if (y > (ACC_W+1)'(OUT_MAX)) begin
            return OUT_MAX;
        end
        if (y < (ACC_W+1)'(OUT_MIN)) begin
            return OUT_MIN;
        end
        return y[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/psum_accum_file.sv
// Per-row accumulator storage: async read, sync write, and a valid bit per row
// telling whether the stored sum belongs to a row still being accumulated.
module psum_accum_file
    import acc_pkg::*;
#(
    parameter  int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int ROW_W = LANES * ACC_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [IDX_W-1:0] idx,
    output logic [ROW_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_data,
    input  logic             wr_last
);

    logic [ROW_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] row_valid_q;
    logic [DEPTH-1:0] row_valid_d;

    assign rd_data  = mem_q[idx];
    assign rd_valid = row_valid_q[idx];

    always_comb begin
        // NOTE: the default copy comes first so every path assigns row_valid_d and no latch is inferred.
        row_valid_d = row_valid_q;
        if (wr_en) begin
            row_valid_d[idx] = !wr_last;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
        if (RESET) begin
            row_valid_q <= '0;
        end else begin
            row_valid_q <= row_valid_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; row_valid alone decides whether its contents are used.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[idx] <= wr_data;
        end
    end

endmodule

// File: rtl/psum_writeback.sv
// Accumulates PE-array partial sums per row, requantizes finished rows to int8
// and queues packed words in a 2-entry FIFO towards the shared SRAM.
module psum_writeback
    import acc_pkg::*;
#(
    parameter  int DEPTH  = 64,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int IN_W   = LANES * PSUM_W,
    localparam int WORD_W = LANES * OUT_W,
    localparam int ROW_W  = LANES * ACC_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               EN,
    input  logic [SHIFT_W-1:0] OSHIFT,
    input  logic [ADDR_W-1:0]  OADDR,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic               in_first,
    input  logic               in_last,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [WORD_W-1:0]  wr_data,
    output logic [ADDR_W-1:0]  wr_count
);

    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic [ROW_W-1:0] row_old;
    logic             row_valid;
    logic [ROW_W-1:0] row_new;
    logic [WORD_W-1:0] word_new;

    wb_word_t          fifo_q [2];
    wb_word_t          fifo_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] wr_count_q, wr_count_d;

    // A non-last beat never touches the FIFO, so it is accepted even when full.
    assign fifo_full = (count_q == 2'd2);
    assign in_ready  = !fifo_full | wr_ready | !in_last;
    assign accept    = in_valid & in_ready & EN;
    assign push      = accept & in_last;
    assign wr_valid  = (count_q != 2'd0);
    assign pop       = wr_valid & wr_ready & EN;

    assign wr_addr  = fifo_q[rd_ptr_q].addr;
    assign wr_data  = fifo_q[rd_ptr_q].data;
    assign wr_count = wr_count_q;

    psum_accum_file #(
        .DEPTH (DEPTH)
    ) u_accum_file (
        .CLK      (CLK),
        .RESET    (RESET),
        .idx      (in_idx),
        .rd_data  (row_old),
        .rd_valid (row_valid),
        .wr_en    (accept),
        .wr_data  (row_new),
        .wr_last  (in_last)
    );

    // Lane adders and requantizers; the fresh sum feeds requant, not the stored row.
    always_comb begin
        logic                     treat_first;
        logic signed [PSUM_W-1:0] lane_in;
        logic signed [ACC_W-1:0]  acc_old;
        logic signed [ACC_W-1:0]  acc_new;
        row_new     = '0;
        word_new    = '0;
        lane_in     = '0;
        acc_old     = '0;
        acc_new     = '0;
        treat_first = in_first | !row_valid;
        for (int i = 0; i < LANES; i++) begin
            lane_in = in_data[PSUM_W*i +: PSUM_W];
            acc_old = row_old[ACC_W*i +: ACC_W];
            acc_new = treat_first ? ACC_W'(lane_in) : sat_acc_add(acc_old, lane_in);
            row_new[ACC_W*i +: ACC_W]  = acc_new;
            word_new[OUT_W*i +: OUT_W] = requant(acc_new, OSHIFT);
        end
    end

    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_count_d = wr_count_q;
        count_d    = count_q + 2'(push) - 2'(pop);
        if (push) begin
            fifo_d[wr_ptr_q].addr = OADDR + ADDR_W'(in_idx);
            fifo_d[wr_ptr_q].data = word_new;
            wr_ptr_d              = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d   = !rd_ptr_q;
            wr_count_d = wr_count_q + ADDR_W'(1);
        end
    end

    // The two FIFO entries are reset so wr_addr/wr_data read zero out of reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            wr_count_q <= '0;
        end else begin
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_count_q <= wr_count_d;
        end
    end

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback: reset, single row, accumulation,
// rounding, back-pressure, mid-operation reset, enable and saturation.
module tb_psum_writeback;

    localparam int LANES  = 16;
    localparam int PSUM_W = 16;
    localparam int OUT_W  = 8;
    localparam int ADDR_W = 13;
    localparam int IDX_W  = 6;
    localparam int IN_W   = LANES * PSUM_W;
    localparam int WORD_W = LANES * OUT_W;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              EN;
    logic [5:0]        OSHIFT;
    logic [ADDR_W-1:0] OADDR;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [IDX_W-1:0]  in_idx;
    logic              in_first;
    logic              in_last;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_count;

    int checks    = 0;
    int failures  = 0;
    int exp_count = 0;

    always #5 CLK = ~CLK;

    psum_writeback dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .OSHIFT   (OSHIFT),
        .OADDR    (OADDR),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_idx   (in_idx),
        .in_first (in_first),
        .in_last  (in_last),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_count (wr_count)
    );

    function automatic logic [IN_W-1:0] fill(input int v);
        logic [IN_W-1:0] d;
        for (int i = 0; i < LANES; i++) d[PSUM_W*i +: PSUM_W] = PSUM_W'(v);
        return d;
    endfunction

    function automatic logic [IN_W-1:0] put(input logic [IN_W-1:0] d, input int i, input int v);
        d[PSUM_W*i +: PSUM_W] = PSUM_W'(v);
        return d;
    endfunction

    function automatic logic [WORD_W-1:0] wfill(input int b);
        logic [WORD_W-1:0] w;
        for (int i = 0; i < LANES; i++) w[OUT_W*i +: OUT_W] = OUT_W'(b);
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] wput(input logic [WORD_W-1:0] w, input int i, input int b);
        w[OUT_W*i +: OUT_W] = OUT_W'(b);
        return w;
    endfunction

    // Called at a falling edge; presents one beat until it is accepted, returns at a falling edge.
    task automatic drive_beat(input logic [IDX_W-1:0] idx, input logic first, input logic last,
                              input logic [IN_W-1:0] data, input logic [5:0] sh);
        bit taken;
        taken    = 1'b0;
        in_valid = 1'b1;
        in_idx   = idx;
        in_first = first;
        in_last  = last;
        in_data  = data;
        OSHIFT   = sh;
        for (int t = 0; t < 20 && !taken; t++) begin
            #1;
            taken = in_ready & EN;
            @(posedge CLK);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        if (!taken) begin
            checks++;
            failures++;
            $display("FAIL beat_accept idx=%0d never accepted within 20 cycles", idx);
        end
    endtask

    task automatic pop_word();
        wr_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        wr_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset();
        RESET    = 1'b1;
        EN       = 1'b1;
        OSHIFT   = '0;
        OADDR    = '0;
        in_valid = 1'b0;
        in_data  = '0;
        in_idx   = '0;
        in_first = 1'b0;
        in_last  = 1'b0;
        wr_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
        checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
        checks++; if (wr_data !== '0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
        checks++; if (wr_count !== '0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        exp_count = 0;
    endtask

    task automatic test_single_row();
        OADDR = 13'h0200;
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL single_pre_valid got=%b exp=0", wr_valid); end
        drive_beat(6'd3, 1'b1, 1'b1, fill(16'h0100), 6'd4);
        checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", wr_valid); end
        checks++; if (wr_data !== wfill(8'h10)) begin failures++; $display("FAIL single_data got=%h exp=%h", wr_data, wfill(8'h10)); end
        checks++; if (wr_addr !== 13'h0203) begin failures++; $display("FAIL single_addr got=%h exp=0203", wr_addr); end
        pop_word();
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", wr_valid); end
        checks++; if (wr_count !== ADDR_W'(exp_count)) begin failures++; $display("FAIL single_count got=%0d exp=%0d", wr_count, exp_count); end
    endtask

    task automatic test_accumulate();
        logic [IN_W-1:0]   d1, d2, d3;
        logic [WORD_W-1:0] exp_w;
        OADDR = 13'h1FFE;
        d1 = put(put(put(put(fill(0), 0, 1000), 1, -2000), 2, 10), 3, 100);
        d2 = put(put(put(put(fill(0), 0, 2000), 1, -2000), 2, 20), 3, -50);
        d3 = put(put(put(put(fill(0), 0, -500), 1, -2000), 2, 30), 3, -40);
        drive_beat(6'd5, 1'b1, 1'b0, d1, 6'd3);
        drive_beat(6'd5, 1'b0, 1'b0, d2, 6'd3);
        drive_beat(6'd5, 1'b0, 1'b1, d3, 6'd3);
        exp_w = wput(wput(wput(wput(wfill(0), 0, 8'h7F), 1, 8'h80), 2, 8'h08), 3, 8'h01);
        checks++; if (wr_data !== exp_w) begin failures++; $display("FAIL accum_data got=%h exp=%h", wr_data, exp_w); end
        checks++; if (wr_addr !== 13'h0003) begin failures++; $display("FAIL accum_addr_wrap got=%h exp=0003", wr_addr); end
        pop_word();
        // Row 5 was closed by the last beat, so in_first=0 must still overwrite.
        d1 = put(fill(-2000), 2, -100);
        drive_beat(6'd5, 1'b0, 1'b0, d1, 6'd5);
        drive_beat(6'd5, 1'b0, 1'b0, d1, 6'd5);
        drive_beat(6'd5, 1'b0, 1'b1, d1, 6'd5);
        exp_w = wput(wfill(8'h80), 2, 8'hF7);
        checks++; if (wr_data !== exp_w) begin failures++; $display("FAIL accum_neg_data got=%h exp=%h", wr_data, exp_w); end
        pop_word();
    endtask

    task automatic test_rounding();
        logic [IN_W-1:0]   d;
        logic [WORD_W-1:0] exp_w;
        OADDR = '0;
        d = put(put(put(put(put(put(put(fill(0), 0, 12), 1, -12), 2, -13), 3, 20), 4, -20), 5, 4), 6, 3);
        drive_beat(6'd9, 1'b1, 1'b1, d, 6'd3);
        exp_w = wput(wput(wput(wput(wput(wput(wfill(0), 0, 8'h02), 1, 8'hFF), 2, 8'hFE), 3, 8'h03), 4, 8'hFE), 5, 8'h01);
        checks++; if (wr_data !== exp_w) begin failures++; $display("FAIL round_data got=%h exp=%h", wr_data, exp_w); end
        checks++; if (wr_addr !== 13'd9) begin failures++; $display("FAIL round_addr got=%h exp=0009", wr_addr); end
        pop_word();
        d = put(put(put(put(fill(0), 0, 127), 1, 128), 2, -128), 3, -129);
        drive_beat(6'd10, 1'b1, 1'b1, d, 6'd0);
        exp_w = wput(wput(wput(wput(wfill(0), 0, 8'h7F), 1, 8'h7F), 2, 8'h80), 3, 8'h80);
        checks++; if (wr_data !== exp_w) begin failures++; $display("FAIL round_out_sat got=%h exp=%h", wr_data, exp_w); end
        pop_word();
    endtask

    task automatic test_back_pressure();
        OADDR    = 13'h0100;
        wr_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; OSHIFT = 6'd0;
        in_idx = 6'd10; in_data = fill(1);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b exp=1", in_ready); end
        @(negedge CLK);
        in_idx = 6'd11; in_data = fill(2);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        @(negedge CLK);
        in_idx = 6'd12; in_data = fill(3);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        checks++; if (wr_data !== wfill(1)) begin failures++; $display("FAIL bp_head got=%h exp=%h", wr_data, wfill(1)); end
        @(negedge CLK);
        checks++; if (wr_data !== wfill(1) || wr_addr !== 13'h010A) begin
            failures++; $display("FAIL bp_hold got=%h/%h exp=%h/010a", wr_data, wr_addr, wfill(1));
        end
        in_last = 1'b0; in_idx = 6'd20;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_nonlast_ready got=%b exp=1", in_ready); end
        @(negedge CLK);
        in_last = 1'b1; in_idx = 6'd12; in_data = fill(3); wr_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_pop_ready got=%b exp=1", in_ready); end
        @(negedge CLK);
        exp_count++;
        checks++; if (wr_data !== wfill(2) || wr_addr !== 13'h010B) begin
            failures++; $display("FAIL bp_word1 got=%h/%h exp=%h/010b", wr_data, wr_addr, wfill(2));
        end
        in_idx = 6'd13; in_data = fill(4);
        @(negedge CLK);
        exp_count++;
        in_valid = 1'b0;
        checks++; if (wr_data !== wfill(3) || wr_addr !== 13'h010C) begin
            failures++; $display("FAIL bp_word2 got=%h/%h exp=%h/010c", wr_data, wr_addr, wfill(3));
        end
        @(negedge CLK);
        exp_count++;
        checks++; if (wr_data !== wfill(4) || wr_addr !== 13'h010D) begin
            failures++; $display("FAIL bp_word3 got=%h/%h exp=%h/010d", wr_data, wr_addr, wfill(4));
        end
        @(negedge CLK);
        exp_count++;
        wr_ready = 1'b0;
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", wr_valid); end
        checks++; if (wr_count !== ADDR_W'(exp_count)) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", wr_count, exp_count); end
    endtask

    task automatic test_reset_mid();
        OADDR    = '0;
        wr_ready = 1'b0;
        drive_beat(6'd7, 1'b1, 1'b0, fill(100), 6'd0);
        drive_beat(6'd7, 1'b0, 1'b0, fill(100), 6'd0);
        drive_beat(6'd8, 1'b1, 1'b1, fill(1), 6'd0);
        checks++; if (wr_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_pre got=%b exp=1", wr_valid); end
        #2;
        RESET = 1'b1;
        #1;
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", wr_valid); end
        checks++; if (wr_count !== '0) begin failures++; $display("FAIL rst_mid_count got=%0d exp=0", wr_count); end
        @(negedge CLK);
        RESET     = 1'b0;
        exp_count = 0;
        drive_beat(6'd7, 1'b0, 1'b1, fill(10), 6'd0);
        checks++; if (wr_data !== wfill(8'h0A)) begin failures++; $display("FAIL rst_mid_stale got=%h exp=%h", wr_data, wfill(8'h0A)); end
        checks++; if (wr_addr !== 13'd7) begin failures++; $display("FAIL rst_mid_addr got=%h exp=0007", wr_addr); end
        pop_word();
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_lost got=%b exp=0", wr_valid); end
        checks++; if (wr_count !== ADDR_W'(exp_count)) begin failures++; $display("FAIL rst_mid_count1 got=%0d exp=%0d", wr_count, exp_count); end
    endtask

    task automatic test_enable();
        EN       = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        in_idx   = 6'd1; in_data = fill(5); OSHIFT = 6'd0;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        EN       = 1'b1;
        checks++; if (wr_valid !== 1'b0) begin failures++; $display("FAIL enable_block got=%b exp=0", wr_valid); end
    endtask

    task automatic test_saturation();
        logic [IN_W-1:0]   d;
        logic [WORD_W-1:0] exp_w;
        OADDR = 13'h0040;
        d = put(put(fill(16'h7FFF), 1, 16'h8000), 2, 0);
        for (int k = 0; k < 300; k++) begin
            drive_beat(6'd20, k == 0, k == 299, d, (k == 299) ? 6'd40 : 6'd0);
        end
        exp_w = wput(wput(wfill(8'h01), 1, 8'hFF), 2, 8'h00);
        checks++; if (wr_data !== exp_w) begin failures++; $display("FAIL sat_data got=%h exp=%h", wr_data, exp_w); end
        checks++; if (wr_addr !== 13'h0054) begin failures++; $display("FAIL sat_addr got=%h exp=0054", wr_addr); end
        pop_word();
        checks++; if (wr_count !== ADDR_W'(exp_count)) begin failures++; $display("FAIL sat_count got=%0d exp=%0d", wr_count, exp_count); end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_accumulate();
        test_rounding();
        test_back_pressure();
        test_reset_mid();
        test_enable();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
